// File: rtl/perceptron_seq_if.sv
// Valid/ready bundle for perceptron_seq: vector/bias/mode in, activated result out.
// The slave modport is the datapath view; master is the upstream/downstream view.
interface perceptron_seq_if #(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 8
);
  logic                      in_valid;
  logic                      in_ready;
  logic [N*DATA_WIDTH-1:0]   x;
  logic [N*DATA_WIDTH-1:0]   w;
  logic [DATA_WIDTH-1:0]     b;
  logic [1:0]                act_mode;
  logic                      out_valid;
  logic                      out_ready;
  logic [DATA_WIDTH-1:0]     y;
  logic                      sat;

  modport slave (
    input  in_valid, x, w, b, act_mode, out_ready,
    output in_ready, out_valid, y, sat
  );

  modport master (
    output in_valid, x, w, b, act_mode, out_ready,
    input  in_ready, out_valid, y, sat
  );
endinterface

// File: rtl/perceptron_seq.sv
// Lane-parallel sequential perceptron: LANES MACs per cycle, then round,
// saturate and activate; result held until the downstream handshake.
module perceptron_seq #(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 2,
  parameter int FRAC       = 4,
  parameter int LEAK_SHIFT = 3,
  localparam int ACC_WIDTH = 2*DATA_WIDTH + $clog2(N) + 2
) (
  input  logic              clk,
  input  logic              rst,
  perceptron_seq_if.slave   io,
  output logic              busy
);

  localparam int BEATS = N / LANES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PW    = 2*DATA_WIDTH;

  localparam logic signed [ACC_WIDTH-1:0] RND  = ACC_WIDTH'(1 <<< (FRAC-1));
  localparam logic signed [ACC_WIDTH-1:0] MAXV =
    ACC_WIDTH'((1 <<< (DATA_WIDTH-1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0] MINV = ~MAXV;

  if (N % LANES != 0) begin : g_chk_lanes
    $error("perceptron_seq: N must be a multiple of LANES");
  end
  if (LANES < 1 || LANES > N) begin : g_chk_range
    $error("perceptron_seq: LANES out of range");
  end
  if (FRAC < 1 || FRAC >= DATA_WIDTH) begin : g_chk_frac
    $error("perceptron_seq: FRAC out of range");
  end

  typedef enum logic [1:0] {IDLE, MAC, ACT, DONE} state_t;

  state_t state, state_nx;

  logic [N*DATA_WIDTH-1:0]        x_r, w_r;
  logic [1:0]                     mode_r;
  logic signed [ACC_WIDTH-1:0]    acc, lane_sum, q;
  logic [BW-1:0]                  beat;
  logic signed [PW-1:0]           xa [LANES];
  logic signed [PW-1:0]           wa [LANES];
  logic signed [DATA_WIDTH-1:0]   v_clip, v_act, y_r;
  logic                           sat_r, clip_hi, clip_lo;
  logic                           accept, last_beat;

  assign io.in_ready  = (state == IDLE) && !rst;
  assign io.out_valid = (state == DONE);
  assign io.y         = y_r;
  assign io.sat       = sat_r;
  assign busy         = (state != IDLE);

  assign accept    = io.in_valid && io.in_ready;
  assign last_beat = (beat == BW'(BEATS-1));

  // operands sign-extended to full product width before multiplying
  always_comb begin
    lane_sum = '0;
    for (int l = 0; l < LANES; l++) begin
      xa[l] = PW'($signed(x_r[(int'(beat)*LANES+l)*DATA_WIDTH +: DATA_WIDTH]));
      wa[l] = PW'($signed(w_r[(int'(beat)*LANES+l)*DATA_WIDTH +: DATA_WIDTH]));
      lane_sum = lane_sum + ACC_WIDTH'(xa[l] * wa[l]);
    end
  end

  always_comb begin
    q       = (acc + RND) >>> FRAC;
    clip_hi = (q > MAXV);
    clip_lo = (q < MINV);
    v_clip  = q[DATA_WIDTH-1:0];
    if (clip_hi) v_clip = MAXV[DATA_WIDTH-1:0];
    if (clip_lo) v_clip = MINV[DATA_WIDTH-1:0];
    v_act = v_clip;
    unique case (1'b1)
      (mode_r == 2'b00): v_act = v_clip;
      (mode_r == 2'b10): v_act = v_clip[DATA_WIDTH-1] ?
                                 (v_clip >>> LEAK_SHIFT) : v_clip;
      default:           v_act = v_clip[DATA_WIDTH-1] ? '0 : v_clip;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept)       state_nx = MAC;
      MAC:  if (last_beat)    state_nx = ACT;
      ACT:                    state_nx = DONE;
      DONE: if (io.out_ready) state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_r    <= '0;
      w_r    <= '0;
      mode_r <= '0;
      acc    <= '0;
      beat   <= '0;
      y_r    <= '0;
      sat_r  <= 1'b0;
    end else begin
      if (accept) begin
        x_r    <= io.x;
        w_r    <= io.w;
        mode_r <= io.act_mode;
        acc    <= $signed({{(ACC_WIDTH-DATA_WIDTH){io.b[DATA_WIDTH-1]}},
                           io.b}) <<< FRAC;
        beat   <= '0;
      end
      if (state == MAC) begin
        acc  <= acc + lane_sum;
        beat <= beat + BW'(1);
      end
      if (state == ACT) begin
        y_r   <= v_act;
        sat_r <= clip_hi | clip_lo;
      end
    end
  end

endmodule
